// File: rtl/uart_param_pkg.sv
// Shared types and helpers for the parametrised UART core.
// Parity modes, FSM encodings and frame-length arithmetic.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic int frame_bits(
    input int db,
    input int par,
    input int sb
  );
    return 1 + db + ((par != PAR_NONE) ? 1 : 0) + sb;
  endfunction

  // Zero-padding to 9 bits leaves the XOR unchanged.
  function automatic logic parity_bit(
    input logic [8:0] d,
    input int         par
  );
    return (par == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_param_if.sv
// User-side bundle of the UART: transmit request and receive report.
// master = user logic, slave = UART core.
interface uart_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, rx_data, rx_done,
    input  rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, rx_data, rx_done,
    output rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_param_rx.sv
// UART receiver: 2-flop synchroniser, falling-edge start detect,
// mid-bit sampling FSM with parity and framing checks.
module uart_param_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_END = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS - 1);

  rx_state_t            st;
  logic                 s1, s2, s3;
  logic                 fall;
  logic                 bit_end;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bits;
  logic [DATA_BITS-1:0] sh;
  logic                 pbit;
  logic                 ferr;

  assign fall    = s3 & ~s2;
  assign bit_end = (cnt == BIT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      s3            <= 1'b1;
      st            <= RX_IDLE;
      cnt           <= '0;
      bits          <= '0;
      sh            <= '0;
      pbit          <= 1'b0;
      ferr          <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      s1      <= rx;
      s2      <= s1;
      s3      <= s2;
      rx_done <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (fall) st <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_END) begin
            cnt  <= '0;
            bits <= '0;
            ferr <= 1'b0;
            // Line back high at half-bit: a glitch, not a start bit.
            st   <= s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            sh  <= {s2, sh[DATA_BITS-1:1]};
            if (bits == DATA_END) begin
              bits <= '0;
              st   <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              bits <= bits + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (bit_end) begin
            cnt  <= '0;
            pbit <= s2;
            st   <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (bits == STOP_END) begin
              rx_done       <= 1'b1;
              rx_data       <= sh;
              rx_frame_err  <= ferr | ~s2;
              rx_parity_err <= (PARITY != PAR_NONE) &&
                (pbit != parity_bit(9'(sh), PARITY));
              st            <= RX_IDLE;
            end else begin
              ferr <= ferr | ~s2;
              bits <= bits + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: inline transmitter FSM plus the
// uart_param_rx receiver; TX and RX run independently.
module uart_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  uart_param_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_END = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS - 1);

  tx_state_t            st;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bits;
  logic [DATA_BITS-1:0] sh;
  logic                 par;
  logic                 busy;
  logic                 bit_end;

  assign bit_end     = (cnt == BIT_END);
  assign bus.tx_busy = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= TX_IDLE;
      cnt  <= '0;
      bits <= '0;
      sh   <= '0;
      par  <= 1'b0;
      tx   <= 1'b1;
      busy <= 1'b0;
    end else begin
      cnt <= (st == TX_IDLE || bit_end) ? '0 : cnt + 1'b1;
      unique case (st)
        TX_IDLE: begin
          tx <= 1'b1;
          if (bus.tx_start) begin
            sh   <= bus.tx_data;
            par  <= parity_bit(9'(bus.tx_data), PARITY);
            tx   <= 1'b0;
            busy <= 1'b1;
            st   <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            tx   <= sh[0];
            bits <= '0;
            st   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            if (bits == DATA_END) begin
              bits <= '0;
              if (PARITY != PAR_NONE) begin
                tx <= par;
                st <= TX_PARITY;
              end else begin
                tx <= 1'b1;
                st <= TX_STOP;
              end
            end else begin
              bits <= bits + 1'b1;
              sh   <= sh >> 1;
              tx   <= sh[1];
            end
          end
        end
        TX_PARITY: begin
          if (bit_end) begin
            tx <= 1'b1;
            st <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (bits == STOP_END) begin
              busy <= 1'b0;
              st   <= TX_IDLE;
            end else begin
              bits <= bits + 1'b1;
            end
          end
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

  uart_param_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY       (PARITY),
    .STOP_BITS    (STOP_BITS)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .rx_data       (bus.rx_data),
    .rx_done       (bus.rx_done),
    .rx_parity_err (bus.rx_parity_err),
    .rx_frame_err  (bus.rx_frame_err)
  );

endmodule

// File: tb/tb_uart_param.sv
// Directed bench: 8N1 loopback (a), 8E1 loopback with parity flip (b),
// 8N2 receiver driven by hand-built frames (c).
module tb_uart_param;

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       poke;
    logic       par;
    logic       perr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic tx_a, tx_b, tx_c, rx_b, rx_c, flip_b;
  int   nvec = 0;
  int   nbad = 0;

  int         done_c = 0;
  logic [7:0] data_c = '0;
  logic       pe_c = 1'b0;
  logic       fe_c = 1'b0;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_param_if #(.DATA_BITS(8)) if_a ();
  uart_param_if #(.DATA_BITS(8)) if_b ();
  uart_param_if #(.DATA_BITS(8)) if_c ();

  assign rx_b = tx_b ^ flip_b;

  uart_param #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .rx(tx_a), .tx(tx_a), .bus(if_a.slave)
  );

  uart_param #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .tx(tx_b), .bus(if_b.slave)
  );

  uart_param #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)
  ) dut_c (
    .clk(clk), .reset(reset), .rx(rx_c), .tx(tx_c), .bus(if_c.slave)
  );

  always @(negedge clk) begin
    if (if_c.rx_done) begin
      done_c <= done_c + 1;
      data_c <= if_c.rx_data;
      pe_c   <= if_c.rx_parity_err;
      fe_c   <= if_c.rx_frame_err;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_ab(input vec_t v);
    int         lat_a = -1, lat_b = -1;
    int         busy_a = 0, busy_b = 0, dn_a = 0, dn_b = 0;
    logic [7:0] da = '0, db = '0;
    logic       pa = 1'b0, fa = 1'b0, pb = 1'b0, fb = 1'b0;
    logic       parbit = 1'b0;
    @(negedge clk);
    if_a.tx_start = 1'b1;
    if_a.tx_data  = v.data;
    if_b.tx_start = 1'b1;
    if_b.tx_data  = v.data;
    @(posedge clk);
    #1;
    if_a.tx_start = 1'b0;
    if_b.tx_start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (if_a.tx_busy) busy_a++;
      if (if_b.tx_busy) busy_b++;
      if (if_a.rx_done) begin
        dn_a++;
        if (lat_a < 0) lat_a = k;
        da = if_a.rx_data;
        pa = if_a.rx_parity_err;
        fa = if_a.rx_frame_err;
      end
      if (if_b.rx_done) begin
        dn_b++;
        if (lat_b < 0) lat_b = k;
        db = if_b.rx_data;
        pb = if_b.rx_parity_err;
        fb = if_b.rx_frame_err;
      end
      if (k == 150) parbit = tx_b;
      flip_b = v.flip && (k >= 144) && (k < 160);
      if (v.poke) begin
        if_a.tx_start = (k == 80);
        if_a.tx_data  = (k == 80) ? 8'hFF : v.data;
      end
    end
    flip_b = 1'b0;
    if_a.tx_start = 1'b0;
    chk("a_data", 32'(da), 32'(v.data));
    chk("a_latency", 32'(lat_a), 32'd155);
    chk("a_done_count", 32'(dn_a), 32'd1);
    chk("a_perr", 32'(pa), 32'd0);
    chk("a_ferr", 32'(fa), 32'd0);
    chk("a_busy_cycles", 32'(busy_a), 32'd160);
    chk("b_data", 32'(db), 32'(v.data));
    chk("b_parity_bit", 32'(parbit), 32'(v.par));
    chk("b_perr", 32'(pb), 32'(v.perr));
    chk("b_ferr", 32'(fb), 32'd0);
    chk("b_latency", 32'(lat_b), 32'd171);
    chk("b_busy_cycles", 32'(busy_b), 32'd176);
  endtask

  task automatic drive_c(input logic [7:0] d, input logic stop2);
    @(negedge clk);
    rx_c = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_c = d[i];
      repeat (16) @(negedge clk);
    end
    rx_c = 1'b1;
    repeat (16) @(negedge clk);
    rx_c = stop2;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    int d0;
    int na, nb;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    flip_b = 1'b0;
    rx_c = 1'b1;
    if_a.tx_start = 1'b0;
    if_a.tx_data  = '0;
    if_b.tx_start = 1'b0;
    if_b.tx_data  = '0;
    if_c.tx_start = 1'b0;
    if_c.tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(if_a.tx_busy), 32'd0);
    chk("rst_rx_data", 32'(if_a.rx_data), 32'd0);
    chk("rst_rx_done", 32'(if_a.rx_done), 32'd0);
    chk("rst_perr", 32'(if_b.rx_parity_err), 32'd0);
    chk("rst_ferr", 32'(if_c.rx_frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_ab(vecs[i]);

    // 8N2 frame with the second stop bit low, then a break.
    d0 = done_c;
    drive_c(8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    chk("c_ferr_done", 32'(done_c), 32'(d0 + 1));
    chk("c_ferr_data", 32'(data_c), 32'h3C);
    chk("c_ferr_flag", 32'(fe_c), 32'd1);
    chk("c_ferr_perr", 32'(pe_c), 32'd0);
    repeat (300) @(negedge clk);
    chk("c_break_no_retrigger", 32'(done_c), 32'(d0 + 1));
    rx_c = 1'b1;
    repeat (40) @(negedge clk);
    rx_c = 1'b0;
    repeat (5) @(negedge clk);
    rx_c = 1'b1;
    repeat (60) @(negedge clk);
    chk("c_glitch_ignored", 32'(done_c), 32'(d0 + 1));
    drive_c(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    chk("c_after_glitch_done", 32'(done_c), 32'(d0 + 2));
    chk("c_after_glitch_data", 32'(data_c), 32'h5A);
    chk("c_after_glitch_ferr", 32'(fe_c), 32'd0);

    // Reset in the middle of a frame on both loopback units.
    @(negedge clk);
    if_a.tx_start = 1'b1;
    if_a.tx_data  = 8'h96;
    if_b.tx_start = 1'b1;
    if_b.tx_data  = 8'h96;
    @(posedge clk);
    #1;
    if_a.tx_start = 1'b0;
    if_b.tx_start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", 32'(if_a.tx_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_tx", 32'(tx_a), 32'd1);
    chk("rst_mid_busy_a", 32'(if_a.tx_busy), 32'd0);
    chk("rst_mid_busy_b", 32'(if_b.tx_busy), 32'd0);
    reset = 1'b0;
    na = 0;
    nb = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (if_a.rx_done) na++;
      if (if_b.rx_done) nb++;
    end
    chk("rst_mid_no_done_a", 32'(na), 32'd0);
    chk("rst_mid_no_done_b", 32'(nb), 32'd0);
    chk("rst_mid_rx_data", 32'(if_a.rx_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
